// File: rtl/if_pkg.sv
// if_pkg: shared types and helpers for the instruction-fetch stage.
// Holds the fetch FSM state enum, byte/offset helpers and the default fetch entry.
package if_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    REDIR = 2'd1,
    FAULT = 2'd2
  } fetch_state_t;

  function automatic int instr_bytes(input int instr_w);
    return instr_w / 8;
  endfunction

  function automatic int off_bits(input int instr_w);
    return $clog2(instr_w / 8);
  endfunction

  localparam int DEF_ADDR_W  = 32;
  localparam int DEF_INSTR_W = 32;

  typedef struct packed {
    logic [DEF_ADDR_W-1:0]  pc;
    logic [DEF_INSTR_W-1:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_fetch_fifo.sv
// if_fetch_fifo: registered prefetch FIFO for {pc,instr} entries.
// Ports: clk, rst (sync, high), push/din, pop, flush, dout (head), count, full, empty.
module if_fetch_fifo #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned W     = 64,
  parameter int unsigned CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [W-1:0]     din,
  input  logic             pop,
  input  logic             flush,
  output logic [W-1:0]     dout,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             push_ok, pop_ok;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == '0);
  assign count = count_q;
  assign dout  = mem_q[rd_ptr_q];

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: fetch PC, imem req/ack port, prefetch FIFO and redirect FSM.
// Ports: clk, rst; branch/jump ctrl+address; imem_req/addr/ack/rdata;
// instr_valid/id_ready/instr/pc to decode; fetch_fault.
// Optional macro IF_MISALIGN_CHECK_EN enables the FAULT state on misaligned targets.
module if_fetch_unit
  import if_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter int unsigned       DEPTH    = 2,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               branch_ctrl,
  input  logic [ADDR_W-1:0]  branch_address,
  input  logic               jump_ctrl,
  input  logic [ADDR_W-1:0]  jump_address,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  input  logic               id_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  pc,
  output logic               fetch_fault
);

  localparam int unsigned EW    = ADDR_W + INSTR_W;
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam logic [ADDR_W-1:0] INC =
    ADDR_W'(instr_bytes(INSTR_W));
  localparam logic [ADDR_W-1:0] ALIGN_MASK =
    ADDR_W'((1 << off_bits(INSTR_W)) - 1);

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;

  logic              redirect;
  logic [ADDR_W-1:0] target_raw;
  logic [ADDR_W-1:0] target;
  logic              push, pop;
  logic [EW-1:0]     head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_full, fifo_empty;

  assign redirect   = jump_ctrl | branch_ctrl;
  assign target_raw = jump_ctrl ? jump_address : branch_address;

`ifdef IF_MISALIGN_CHECK_EN
  logic              misaligned;
  logic [ADDR_W-1:0] fault_pc_q, fault_pc_d;
  assign misaligned = |(target_raw & ALIGN_MASK);
  assign target     = target_raw;
`else
  // Low bits dropped so a sloppy target still fetches the enclosing word.
  assign target     = target_raw & ~ALIGN_MASK;
`endif

  // Registered count gates req, so a same-cycle pop cannot open a full FIFO.
  assign imem_req = !rst && (state_q == FETCH) &&
                    (fifo_count < CNT_W'(DEPTH));
  assign imem_addr = fetch_pc_q;

  // Masked during a redirect so the stale head is never consumed.
  assign instr_valid = !rst && !fifo_empty && !redirect;

  assign push = imem_req && imem_ack && !redirect && !fifo_full;
  assign pop  = instr_valid && id_ready;

  if_fetch_fifo #(
    .DEPTH (DEPTH),
    .W     (EW),
    .CNT_W (CNT_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   ({fetch_pc_q, imem_rdata}),
    .pop   (pop),
    .flush (redirect),
    .dout  (head),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
`ifdef IF_MISALIGN_CHECK_EN
    fault_pc_d = fault_pc_q;
`endif
    if (redirect) begin
`ifdef IF_MISALIGN_CHECK_EN
      if (misaligned) begin
        state_d    = FAULT;
        fault_pc_d = target;
      end else begin
        state_d    = REDIR;
        fetch_pc_d = target;
      end
`else
      state_d    = REDIR;
      fetch_pc_d = target;
`endif
    end else begin
      if (push) begin
        fetch_pc_d = fetch_pc_q + INC;
      end
      if (state_q == REDIR) begin
        state_d = FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
    end
  end

`ifdef IF_MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      fault_pc_q <= '0;
    end else begin
      fault_pc_q <= fault_pc_d;
    end
  end

  assign fetch_fault = (state_q == FAULT);

  always_comb begin
    pc    = '0;
    instr = '0;
    if (state_q == FAULT) begin
      pc = fault_pc_q;
    end else if (!fifo_empty) begin
      pc    = head[EW-1:INSTR_W];
      instr = head[INSTR_W-1:0];
    end
  end
`else
  assign fetch_fault = 1'b0;
  assign pc    = fifo_empty ? '0 : head[EW-1:INSTR_W];
  assign instr = fifo_empty ? '0 : head[INSTR_W-1:0];
`endif

endmodule
